// File: rtl/main_memory_model.sv
// Block-granular main-memory model behind a cache: one request in flight,
// fixed response latency, out-of-range or misaligned requests answered with an error.
module main_memory_model #(
  parameter int NUM_BLOCKS    = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int LATENCY       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_error,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int OFS    = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int HI_LSB = OFS + IDX_W;
  localparam logic [ADDRESS_WIDTH-1:0] OFS_MASK =
    (ADDRESS_WIDTH'(1) << OFS) - ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  cap_write;
  logic                  cap_err;
  logic [IDX_W-1:0]      cap_idx;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] mem [NUM_BLOCKS];

  logic                  req_err;
  logic [IDX_W-1:0]      req_idx;

  // Any address bit above the index field, or any byte-offset bit, makes the request an error.
  always_comb begin
    req_idx = req_addr[OFS +: IDX_W];
    req_err = ((req_addr >> HI_LSB) != '0) || ((req_addr & OFS_MASK) != '0);
  end

  assign dbg_state = state;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready is high only in IDLE; resp_valid/rdata/error hold until resp_ready is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_err    <= 1'b0;
      cap_idx    <= '0;
      cap_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_err   <= req_err;
            cap_idx   <= req_idx;
            cap_wdata <= req_wdata;
            cnt       <= 4'(LATENCY - 1);
            state     <= WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= cap_err;
            // Commit happens only here, so an abandoned transaction never touches storage.
            if (cap_err) begin
              resp_rdata <= '0;
            end else if (cap_write) begin
              mem[cap_idx] <= cap_wdata;
              resp_rdata   <= '0;
            end else begin
              resp_rdata <= mem[cap_idx];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model: vector table of single transactions plus
// hand-written stall, mid-transaction reset and LATENCY=1 throughput sequences.
module tb_main_memory_model;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_write, resp_ready;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         req_ready, resp_valid, resp_error, busy;
  logic [127:0] resp_rdata;
  logic [1:0]   dbg_state;

  logic         req_valid1, req_write1, resp_ready1;
  logic [31:0]  req_addr1;
  logic [127:0] req_wdata1;
  logic         req_ready1, resp_valid1, resp_error1, busy1;
  logic [127:0] resp_rdata1;
  logic [1:0]   dbg_state1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_memory_model dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .busy(busy), .dbg_state(dbg_state)
  );

  main_memory_model #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_error(resp_error1),
    .busy(busy1), .dbg_state(dbg_state1)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  localparam logic [127:0] DATA_D = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DATA_E = 128'hDEADBEEFCAFEF00D1122334455667788;
  localparam logic [127:0] DATA_F = 128'hFFFF0000A5A55A5A0F0F0F0F80000001;
  localparam int NUM_VEC = 15;

  vec_t vecs [NUM_VEC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request on the default-latency instance with resp_ready held high.
  task automatic do_txn(input string id, input logic w, input logic [31:0] a,
                        input logic [127:0] d, input logic [127:0] er, input logic ee);
    int lat;
    check({id, " req_ready_before"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    check({id, " busy_in_wait"}, {126'd0, busy, req_ready}, 128'b10);
    check({id, " rdata_idle_zero"}, resp_rdata, 128'd0);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({id, " latency"}, 128'(lat), 128'(4));
    check({id, " rdata"}, resp_rdata, er);
    check({id, " error"}, 128'(resp_error), 128'(ee));
    @(negedge clk);
    check({id, " ready_after"}, {126'd0, req_ready, resp_valid}, 128'b10);
  endtask

  initial begin
    int n_valid, first_valid, n_acc;
    int acc_idx [4];

    vecs[0]  = '{1'b0, 32'h0000_0030, 128'd0,  128'd0,  1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0070, DATA_D,  128'd0,  1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0070, 128'd0,  DATA_D,  1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0080, 128'd0,  128'd0,  1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0014, 128'd0,  128'd0,  1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0080, DATA_E,  128'd0,  1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 128'd0,  128'd0,  1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0010, DATA_E,  128'd0,  1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0010, 128'd0,  DATA_E,  1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0020, DATA_F,  128'd0,  1'b0};
    vecs[10] = '{1'b1, 32'h1000_0070, DATA_E,  128'd0,  1'b1};
    vecs[11] = '{1'b0, 32'h0000_0070, 128'd0,  DATA_D,  1'b0};
    vecs[12] = '{1'b0, 32'h0000_0020, 128'd0,  DATA_F,  1'b0};
    vecs[13] = '{1'b1, 32'h0000_0008, DATA_F,  128'd0,  1'b1};
    vecs[14] = '{1'b0, 32'h0000_0000, 128'd0,  128'd0,  1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset req_ready", 128'(req_ready), 128'(1));
    check("reset resp_valid/error/busy", {125'd0, resp_valid, resp_error, busy}, 128'd0);
    check("reset rdata", resp_rdata, 128'd0);
    check("reset state", 128'(dbg_state), 128'd0);

    for (int i = 0; i < NUM_VEC; i++)
      do_txn($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);

    // Response stalled for five cycles; a request pulse mid-stall must be dropped.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_valid = 0;
    while (!resp_valid && n_valid < 40) begin
      @(negedge clk);
      n_valid++;
    end
    check("stall latency", 128'(n_valid), 128'(4));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d valid/err/busy/ready", k),
            {124'd0, resp_valid, resp_error, busy, req_ready}, 128'b1010);
      check($sformatf("stall%0d rdata", k), resp_rdata, DATA_D);
      req_valid = (k == 1); req_write = 1'b1; req_addr = 32'h0; req_wdata = DATA_F;
      @(negedge clk);
    end
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall release", {126'd0, req_ready, resp_valid}, 128'b10);
    do_txn("stall_ignored", 1'b0, 32'h0, 128'd0, 128'd0, 1'b0);

    // Reset two edges after accepting a write: no response, nothing committed.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = DATA_F;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst ready/busy/valid", {125'd0, req_ready, busy, resp_valid}, 128'b100);
    n_valid = 0;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid) n_valid++;
      @(negedge clk);
    end
    check("midrst no response", 128'(n_valid), 128'd0);
    do_txn("midrst read10", 1'b0, 32'h10, 128'd0, 128'd0, 1'b0);
    do_txn("midrst read70", 1'b0, 32'h70, 128'd0, 128'd0, 1'b0);

    // LATENCY=1 instance: continuous read requests, one accept per three cycles.
    req_valid1 = 1'b1; req_addr1 = 32'h0;
    n_acc = 0; first_valid = -1; n_valid = 0;
    for (int c = 0; c < 9; c++) begin
      if (req_valid1 && req_ready1) begin
        if (n_acc < 4) acc_idx[n_acc] = c;
        n_acc++;
      end
      if (resp_valid1) begin
        n_valid++;
        if (first_valid < 0) first_valid = c;
      end
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    check("lat1 accepts", 128'(n_acc), 128'd3);
    check("lat1 first accept", 128'(acc_idx[0]), 128'd0);
    check("lat1 accept gap", 128'(acc_idx[1] - acc_idx[0]), 128'd3);
    check("lat1 first resp", 128'(first_valid), 128'd2);
    check("lat1 resp count", 128'(n_valid), 128'd3);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
